fetch_unit: RTL

- Instruction fetch pipeline stage. Owns the fetch PC and drives the instruction-memory bus request/acknowledge port.
- Supplies the decode stage with an instruction word, its PC, and the fetch-stall flag. Decode latches the word when no core stall is active.
- Applies branch/jump redirects after the delay slot, and applies pipeline-drop (exception) redirects immediately.

---
 rtl/fetch_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction fetch pipeline stage.
//
// Owns the fetch PC, issues one instruction-bus read at a time and hands the
// returned word to decode. Branch/jump redirects take effect after the delay
// slot; pipeline drops (exception/ERET) redirect as soon as the bus allows.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   o_IAddr, o_IRdC    instruction bus address / read request
//   i_IData, i_IRdy    instruction bus read data / acknowledge
//   i_exec_stall       execute stage stall
//   i_mem_stall        memory stage stall
//   i_jump_valid/addr  one-cycle redirect strobe and target
//   i_drop/addr        pipeline flush and its target
//   o_instr, o_pc      instruction word for decode and its PC
//   o_fetch_stall      1 = o_instr not valid, decode must not latch
//   o_addr_err         misaligned-fetch pulse (FETCH_ALIGN_CHECK_EN only)
//
// Build option: define FETCH_ALIGN_CHECK_EN to trap misaligned fetch PCs.
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned            ADDR_WIDTH  = 32,
   parameter int unsigned            INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]  RESET_ADDR  = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [ADDR_WIDTH-1:0]  o_IAddr,
   output logic                   o_IRdC,
   input  logic [INSTR_WIDTH-1:0] i_IData,
   input  logic                   i_IRdy,
   input  logic                   i_exec_stall,
   input  logic                   i_mem_stall,
   input  logic                   i_jump_valid,
   input  logic [ADDR_WIDTH-1:0]  i_jump_addr,
   input  logic                   i_drop,
   input  logic [ADDR_WIDTH-1:0]  i_drop_addr,
   output logic [INSTR_WIDTH-1:0] o_instr,
   output logic [ADDR_WIDTH-1:0]  o_pc,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic                   o_addr_err,
`endif
   output logic                   o_fetch_stall
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      VALID = 2'd1
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      ERR   = 2'd2
`endif
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
   logic                    jmp_pend_q, jmp_pend_d;
   logic [ADDR_WIDTH-1:0]   jmp_tgt_q, jmp_tgt_d;
   logic                    drop_pend_q, drop_pend_d;
   logic [ADDR_WIDTH-1:0]   drop_tgt_q, drop_tgt_d;
   logic [INSTR_WIDTH-1:0]  instr_d;
   logic [ADDR_WIDTH-1:0]   pc_d;
   logic                    req_d;
   logic                    stall_d;
   logic                    err_d;

   logic                    consume;
   logic                    drop_now;
   logic [ADDR_WIDTH-1:0]   drop_tgt_eff;
   logic                    jmp_now;
   logic [ADDR_WIDTH-1:0]   jmp_tgt_eff;

   assign o_IAddr  = fetch_pc_q;
   assign consume  = !i_exec_stall && !i_mem_stall && !o_fetch_stall;

   // A strobe arriving this cycle overrides an older pending target.
   assign drop_now     = drop_pend_q || i_drop;
   assign drop_tgt_eff = i_drop ? i_drop_addr : drop_tgt_q;
   assign jmp_now      = jmp_pend_q || i_jump_valid;
   assign jmp_tgt_eff  = i_jump_valid ? i_jump_addr : jmp_tgt_q;

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      jmp_pend_d  = jmp_pend_q;
      jmp_tgt_d   = jmp_tgt_q;
      drop_pend_d = drop_pend_q;
      drop_tgt_d  = drop_tgt_q;
      instr_d     = o_instr;
      pc_d        = o_pc;
      err_d       = 1'b0;

      case (state_q)
         FETCH: begin
            if (!o_IRdC) begin
               // Just out of reset: nothing on the bus yet, so a drop can
               // retarget directly; a jump still waits for its delay slot.
               if (i_drop) begin
                  fetch_pc_d = i_drop_addr;
                  jmp_pend_d = 1'b0;
               end else if (i_jump_valid) begin
                  jmp_pend_d = 1'b1;
                  jmp_tgt_d  = i_jump_addr;
               end
            end else if (i_IRdy) begin
               jmp_pend_d  = 1'b0;
               drop_pend_d = 1'b0;
               if (drop_now) begin
                  // Flushed word is discarded; refetch at the drop target.
                  fetch_pc_d = drop_tgt_eff;
                  instr_d    = '0;
               end else begin
                  instr_d    = i_IData;
                  pc_d       = fetch_pc_q;
                  fetch_pc_d = jmp_now ? jmp_tgt_eff
                                       : fetch_pc_q + ADDR_WIDTH'(4);
                  state_d    = VALID;
               end
            end else begin
               // Bus transaction in flight cannot be aborted: remember it.
               if (i_drop) begin
                  drop_pend_d = 1'b1;
                  drop_tgt_d  = i_drop_addr;
                  jmp_pend_d  = 1'b0;
               end else if (i_jump_valid && !drop_pend_q) begin
                  jmp_pend_d = 1'b1;
                  jmp_tgt_d  = i_jump_addr;
               end
            end
         end

         VALID: begin
            if (i_drop) begin
               instr_d    = '0;
               pc_d       = '0;
               fetch_pc_d = i_drop_addr;
               jmp_pend_d = 1'b0;
               state_d    = FETCH;
            end else begin
               // Held word is the delay slot; only the next fetch moves.
               if (i_jump_valid) fetch_pc_d = i_jump_addr;
               if (consume)      state_d    = FETCH;
            end
         end

`ifdef FETCH_ALIGN_CHECK_EN
         ERR: begin
            if (i_drop) begin
               fetch_pc_d = i_drop_addr;
               state_d    = FETCH;
            end
         end
`endif

         default: state_d = FETCH;
      endcase

`ifdef FETCH_ALIGN_CHECK_EN
      // Any entry into FETCH with a misaligned PC is diverted to ERR, so a
      // request is only ever issued for an aligned address.
      if (state_d == FETCH && fetch_pc_d[1:0] != 2'b00) begin
         state_d = ERR;
         instr_d = '0;
         err_d   = (state_q != ERR);
      end
`endif

      req_d   = (state_d == FETCH);
      stall_d = (state_d != VALID);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= FETCH;
         fetch_pc_q    <= RESET_ADDR;
         jmp_pend_q    <= 1'b0;
         jmp_tgt_q     <= '0;
         drop_pend_q   <= 1'b0;
         drop_tgt_q    <= '0;
         o_instr       <= '0;
         o_pc          <= '0;
         o_IRdC        <= 1'b0;
         o_fetch_stall <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
         o_addr_err    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         jmp_pend_q    <= jmp_pend_d;
         jmp_tgt_q     <= jmp_tgt_d;
         drop_pend_q   <= drop_pend_d;
         drop_tgt_q    <= drop_tgt_d;
         o_instr       <= instr_d;
         o_pc          <= pc_d;
         o_IRdC        <= req_d;
         o_fetch_stall <= stall_d;
`ifdef FETCH_ALIGN_CHECK_EN
         o_addr_err    <= err_d;
`else
         if (err_d) o_fetch_stall <= 1'b1;
`endif
      end
   end

endmodule
